// File: rtl/mrs_pkg.sv
// Shared types and constants for the LDM/STM register-list sequencer.
package mrs_pkg;
  localparam int MRS_LIST_W  = 16;
  localparam int MRS_OUT_W   = 32;
  localparam int MRS_OUT_LSB = 16;
  localparam int MRS_CNT_W   = 5;

  typedef enum logic {MRS_IDLE, MRS_ACTIVE} mrs_state_e;

  function automatic logic [MRS_CNT_W-1:0] popcount16(input logic [15:0] v);
    logic [MRS_CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + {{(MRS_CNT_W-1){1'b0}}, v[i]};
    return c;
  endfunction
endpackage

// File: rtl/mrs_pick.sv
// One-hot isolator: lowest (desc=0) or highest (desc=1) set bit of mask.
module mrs_pick import mrs_pkg::*; #(
  parameter int LIST_W = MRS_LIST_W
) (
  input  logic [LIST_W-1:0] mask,
  input  logic              desc,
  output logic [LIST_W-1:0] oneHot
);
  logic [LIST_W-1:0] rev, revPick, lowPick, highPick;

  // Highest-bit pick is the lowest-bit trick applied to the bit-reversed mask.
  for (genvar i = 0; i < LIST_W; i++) begin : gRev
    assign rev[i]      = mask[LIST_W-1-i];
    assign highPick[i] = revPick[LIST_W-1-i];
  end

  assign lowPick = mask & (-mask);
  assign revPick = rev & (-rev);
  assign oneHot  = desc ? highPick : lowPick;
endmodule

// File: rtl/multi_reg_sequencer.sv
// Steps through an LDM/STM register list, one one-hot register per Next.
// Optional R15 detect on PcSel when MRS_PC_DETECT_EN is defined.
module multi_reg_sequencer import mrs_pkg::*; #(
  parameter int LIST_W  = MRS_LIST_W,
  parameter int OUT_W   = MRS_OUT_W,
  parameter int OUT_LSB = MRS_OUT_LSB
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 Load,
  input  logic [LIST_W-1:0]    RegList,
  input  logic                 Desc,
  input  logic                 Next,
  output logic [OUT_W-1:0]     OneHot,
  output logic                 Busy,
  output logic                 Last,
  output logic                 Done,
  output logic                 Empty,
  output logic [MRS_CNT_W-1:0] Count,
  output logic                 PcSel
);
  mrs_state_e        state;
  logic [LIST_W-1:0] mask, pick;
  logic              descQ;

  mrs_pick #(.LIST_W(LIST_W)) uPick (.mask(mask), .desc(descQ), .oneHot(pick));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= MRS_IDLE;
      mask  <= '0;
      descQ <= 1'b0;
      Count <= '0;
      Empty <= 1'b0;
      Done  <= 1'b0;
    end else begin
      Done <= 1'b0;
      // Load wins over Next in any state; an aborted sequence never pulses Done.
      if (Load) begin
        descQ <= Desc;
        Count <= popcount16(RegList);
        mask  <= RegList;
        if (RegList == '0) begin
          Empty <= 1'b1;
          Done  <= 1'b1;
          state <= MRS_IDLE;
        end else begin
          Empty <= 1'b0;
          state <= MRS_ACTIVE;
        end
      end else if (state == MRS_ACTIVE && Next) begin
        mask <= mask & ~pick;
        if (mask == pick) begin
          state <= MRS_IDLE;
          Done  <= 1'b1;
        end
      end
    end
  end

  assign Busy = (state == MRS_ACTIVE);
  assign Last = Busy & (popcount16(mask) == MRS_CNT_W'(1));

  always_comb begin
    OneHot = '0;
    OneHot[OUT_LSB +: LIST_W] = Busy ? pick : '0;
  end

`ifdef MRS_PC_DETECT_EN
  assign PcSel = Busy & pick[LIST_W-1];
`else
  assign PcSel = 1'b0;
`endif
endmodule

// File: tb/tb_multi_reg_sequencer.sv
// Directed spec scenarios plus randomized traffic against a queue-based reference model.
module tb_multi_reg_sequencer;
  logic        Clk = 1'b0, Reset_n = 1'b0, Load = 1'b0, Desc = 1'b0, Next = 1'b0;
  logic [15:0] RegList = '0;
  logic [31:0] OneHot;
  logic        Busy, Last, Done, Empty, PcSel;
  logic [4:0]  Count;

  int checks = 0, failures = 0;
  int q[$];
  bit eDone = 0, eEmpty = 0;
  int eCount = 0;

  multi_reg_sequencer dut (
    .Clk(Clk), .Reset_n(Reset_n), .Load(Load), .RegList(RegList), .Desc(Desc),
    .Next(Next), .OneHot(OneHot), .Busy(Busy), .Last(Last), .Done(Done),
    .Empty(Empty), .Count(Count), .PcSel(PcSel)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    logic [31:0] eOh;
    bit eBusy, ePc;
    eBusy = (q.size() > 0);
    eOh   = eBusy ? (32'h1 << (16 + q[0])) : 32'h0;
`ifdef MRS_PC_DETECT_EN
    ePc = eBusy && (q[0] == 15);
`else
    ePc = 1'b0;
`endif
    chk({tag, ".onehot"}, OneHot, eOh);
    chk({tag, ".busy"},   {31'b0, Busy},  {31'b0, eBusy});
    chk({tag, ".last"},   {31'b0, Last},  {31'b0, q.size() == 1});
    chk({tag, ".done"},   {31'b0, Done},  {31'b0, eDone});
    chk({tag, ".empty"},  {31'b0, Empty}, {31'b0, eEmpty});
    chk({tag, ".count"},  {27'b0, Count}, eCount);
    chk({tag, ".pcsel"},  {31'b0, PcSel}, {31'b0, ePc});
  endtask

  // Drive one cycle from a falling edge, update the model at the rising edge,
  // then check on the next falling edge.
  task automatic cyc(input string tag, input bit ld, input logic [15:0] lst,
                     input bit ds, input bit nx);
    Load = ld; RegList = lst; Desc = ds; Next = nx;
    @(posedge Clk);
    eDone = 0;
    if (ld) begin
      q.delete();
      if (ds) begin
        for (int i = 15; i >= 0; i--) if (lst[i]) q.push_back(i);
      end else begin
        for (int i = 0; i < 16; i++) if (lst[i]) q.push_back(i);
      end
      eCount = q.size();
      eEmpty = (q.size() == 0);
      eDone  = (q.size() == 0);
    end else if (nx && q.size() > 0) begin
      void'(q.pop_front());
      eDone = (q.size() == 0);
    end
    @(negedge Clk);
    Load = 0; Next = 0;
    checkAll(tag);
  endtask

  initial begin
    #2;
    chk("rst0.onehot", OneHot, 32'h0);
    chk("rst0.busy", {31'b0, Busy}, 32'h0);
    chk("rst0.done", {31'b0, Done}, 32'h0);
    chk("rst0.count", {27'b0, Count}, 32'h0);
    @(negedge Clk);
    Reset_n = 1'b1;
    cyc("idle_next", 0, 16'h0, 0, 1);

    // 1: ascending over R0, R15
    cyc("t1.load", 1, 16'h8001, 0, 0);
    chk("t1.oh_abs", OneHot, 32'h0001_0000);
    chk("t1.cnt_abs", {27'b0, Count}, 32'd2);
    cyc("t1.n1", 0, 16'h0, 0, 1);
    chk("t1.oh2_abs", OneHot, 32'h8000_0000);
    cyc("t1.n2", 0, 16'h0, 0, 1);
    chk("t1.done_abs", {31'b0, Done}, 32'h1);
    cyc("t1.after", 0, 16'h0, 0, 0);

    // 2: descending over R8, R2, R0
    cyc("t2.load", 1, 16'h0105, 1, 0);
    chk("t2.oh_abs", OneHot, 32'h0100_0000);
    cyc("t2.n1", 0, 16'h0, 0, 1);
    cyc("t2.n2", 0, 16'h0, 0, 1);
    chk("t2.oh3_abs", OneHot, 32'h0001_0000);
    cyc("t2.n3", 0, 16'h0, 0, 1);

    // 3: empty list
    cyc("t3.load", 1, 16'h0000, 0, 0);
    chk("t3.empty_abs", {31'b0, Empty}, 32'h1);
    cyc("t3.after", 0, 16'h0, 0, 0);

    // 4: abort with simultaneous Load+Next
    cyc("t4.load", 1, 16'h00F0, 0, 0);
    cyc("t4.n1", 0, 16'h0, 0, 1);
    cyc("t4.reload", 1, 16'h0003, 0, 1);
    chk("t4.oh_abs", OneHot, 32'h0001_0000);
    cyc("t4.n2", 0, 16'h0, 0, 1);

    // 5: asynchronous reset mid-sequence
    #2 Reset_n = 1'b0;
    #1;
    chk("t5.onehot", OneHot, 32'h0);
    chk("t5.busy", {31'b0, Busy}, 32'h0);
    chk("t5.last", {31'b0, Last}, 32'h0);
    chk("t5.done", {31'b0, Done}, 32'h0);
    chk("t5.empty", {31'b0, Empty}, 32'h0);
    chk("t5.count", {27'b0, Count}, 32'h0);
    chk("t5.pcsel", {31'b0, PcSel}, 32'h0);
    q.delete(); eDone = 0; eEmpty = 0; eCount = 0;
    @(negedge Clk);
    Reset_n = 1'b1;
    cyc("t5.next", 0, 16'h0, 0, 1);
    cyc("t5.idle", 0, 16'h0, 0, 0);

    // 6: full list, 16 steps
    cyc("t6.load", 1, 16'hFFFF, 0, 0);
    chk("t6.cnt_abs", {27'b0, Count}, 32'd16);
    for (int i = 0; i < 16; i++) cyc("t6.step", 0, 16'h0, 0, 1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [15:0] lst;
      r = $urandom_range(0, 9);
      lst = (r == 0) ? 16'h0000 : (r == 1) ? 16'hFFFF : 16'($urandom);
      cyc("rnd", ($urandom_range(0, 7) == 0), lst, 1'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
